bus_apb_bridge: RTL
===================

# bus_apb_bridge

Parametrised bridge from the team's simple request/ready bus (`bus_ena`/`bus_wstb`/`bus_addr`/`bus_wdata` → `bus_ready`/`bus_rdata`/`bus_slverr`) to an APB4 segment of `NUM_SLAVES` peripherals. It sits behind a bus master and performs:
- address decode into per-slave `psel`;
- the APB SETUP/ACCESS sequence with unbounded wait states;
- a per-transfer timeout;
- an error response for unmapped addresses.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width, both sides.
- `DATA_WIDTH`, 32, data width; must be 8, 16 or 32.
- `NUM_SLAVES`, 4, number of APB slaves (1..16).
- `BASE_ADDR`, 0, start of the decoded window.
- `SLAVE_SPAN_LOG2`, 12, log2 of bytes per slave window.
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bus_ena` in 1: request; held high with stable addr/wstb/wdata until `bus_ready`.
- `bus_wstb` in `DATA_WIDTH/8`: byte strobes; nonzero = write, zero = read.
- `bus_addr` in `ADDR_WIDTH`: byte address.
- `bus_wdata` in `DATA_WIDTH`: write data.
- `bus_ready` out 1: single-cycle completion pulse.
- `bus_rdata` out `DATA_WIDTH`: read data, valid while `bus_ready`=1.
- `bus_slverr` out 1: error, valid while `bus_ready`=1.
- `paddr` out `ADDR_WIDTH`; `pwrite` out 1; `pwdata` out `DATA_WIDTH`; `pstrb` out `DATA_WIDTH/8`; `pprot` out 3 (constant 3'b000).
- `psel` out `NUM_SLAVES`: one-hot or zero.
- `penable` out 1.
- `prdata` in `NUM_SLAVES*DATA_WIDTH`: slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `pready` in `NUM_SLAVES`; `pslverr` in `NUM_SLAVES`.
- `timeout_evt` out 1: one-cycle pulse when a transfer is aborted by timeout.

## Operation
Decode is combinational on `bus_addr`:
- offset = `bus_addr` − `BASE_ADDR`.
- idx = offset >> `SLAVE_SPAN_LOG2`.
- Hit iff `bus_addr` ≥ `BASE_ADDR` and idx < `NUM_SLAVES`.
- `paddr` carries the full `bus_addr`, not the offset.

FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: outputs quiet.
  - `bus_ena`=1 and hit → SETUP. Latch addr, wstb, wdata and idx.
  - `bus_ena`=1 and miss → RESP with slverr=1, rdata=0. No APB activity.
- SETUP: `psel[idx]`=1, `penable`=0. Transaction fields are driven on the APB. Always → ACCESS.
- ACCESS: `psel[idx]`=1, `penable`=1. The timeout counter increments each cycle.
  - `pready[idx]`=1 → RESP. Capture `prdata[idx]` (reads only; writes return 0) and `pslverr[idx]`.
  - Counter reaches `TIMEOUT_CYCLES` with no `pready` → RESP with slverr=1, rdata=0, `timeout_evt`=1.
- RESP: `bus_ready`=1 for exactly one cycle, with registered rdata/slverr. Always → IDLE.

APB field rules:
- Write: `pwrite`=1, `pstrb`=wstb, `pwdata`=wdata.
- Read: `pwrite`=0, `pstrb`=0, `pwdata`=0.
- APB outputs are zero in IDLE and RESP.

Protocol violations:
- `bus_ena` dropping mid-transfer does not abort. The APB transfer completes and `bus_ready` still pulses.
- `pready`/`pslverr` of unselected slaves are ignored.

## Timing
- All outputs are registered. Reset value of every output is 0, applied immediately on `rst_n` low, including mid-transfer. After reset the state is IDLE and the counter is 0.
- Latency, `bus_ena` sampled at edge N:
  - zero-wait slave: SETUP in N+1, ACCESS in N+2, `bus_ready` in N+3;
  - each wait state adds 1 cycle;
  - decode miss: `bus_ready` in N+1.
- Throughput: a back-to-back hit costs 4 cycles. `bus_ena` held high in the RESP cycle is sampled as a new request in the following IDLE cycle.
- Timeout: with `TIMEOUT_CYCLES`=T>0, a slave that never asserts `pready` gives `bus_ready`+slverr at N+3+T. `pready` arriving in the same cycle the counter reaches T wins: normal completion, no `timeout_evt`.
- Counter width: clog2(`TIMEOUT_CYCLES`+1). It resets on entry to SETUP and saturates; it never wraps.

## Structure
Package `bus_apb_pkg` holds:
- the state enum `apb_state_e` (IDLE, SETUP, ACCESS, RESP);
- the `APB_PROT_DEFAULT` constant (3'b000);
- the function `bus_is_write(wstb)`.

Sub-module `bus_apb_decoder`: combinational, parametrised by `ADDR_WIDTH`, `NUM_SLAVES`, `BASE_ADDR` and `SLAVE_SPAN_LOG2`. Outputs `hit` and `idx`. Reused by future bus fabrics.

## Test plan
- Write, zero-wait: addr 0x0000_1004, wstb 4'b0011, wdata 0xDEAD_BEEF → `psel`=4'b0010 at N+1, `penable` at N+2, `pstrb`=3, `bus_ready` at N+3 with slverr=0.
- Read, 3 wait states: addr 0x0000_3010, slave 3 returns 0x1234_5678 with `pready` at N+5 → `bus_ready` at N+6 with rdata=0x1234_5678; `pwrite`=0 and `pstrb`=0 throughout.
- Decode miss: addr 0x0000_4000, `NUM_SLAVES`=4 → `bus_ready`+slverr at N+1, `psel` never asserted.
- Timeout: T=16, slave 0 never ready → `bus_ready`+slverr+`timeout_evt` at N+19. Repeat with `pready` at exactly ACCESS cycle 16 → normal completion, no `timeout_evt`.
- Slave error plus back-to-back: slave 2 read with `pslverr`=1 gives slverr=1, rdata from slave. `bus_ena` held through RESP with new addr 0x0000_0000 → next SETUP exactly 2 cycles after the `bus_ready` cycle (4-cycle period).
- Reset mid-ACCESS: assert `rst_n`=0 while `penable`=1 → all outputs 0 within the same cycle. A fresh request after release completes normally.

Source files
------------

// File: rtl/bus_apb_pkg.sv
// Shared types and helpers for the request/ready bus to APB4 bridge.
package bus_apb_pkg;

  localparam int unsigned STRB_MAX_W = 4;
  localparam logic [2:0]  APB_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Any asserted byte strobe marks a write; all-zero strobes mark a read.
  function automatic logic bus_is_write(input logic [STRB_MAX_W-1:0] wstb);
    return |wstb;
  endfunction

endpackage

// File: rtl/bus_apb_decoder.sv
// Combinational address decoder: maps a byte address onto one of NUM_SLAVES
// equally sized windows starting at BASE_ADDR.
module bus_apb_decoder #(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            NUM_SLAVES      = 4,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter int unsigned            SLAVE_SPAN_LOG2 = 12,
  parameter int unsigned            IDX_W           = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] slot;

  always_comb begin
    offset = addr - BASE_ADDR;
    slot   = offset >> SLAVE_SPAN_LOG2;
    hit    = (addr >= BASE_ADDR) && (slot < ADDR_WIDTH'(NUM_SLAVES));
    idx    = IDX_W'(slot);
  end

endmodule

// File: rtl/bus_apb_bridge.sv
// Bridge from the simple request/ready bus to an APB4 segment: decode,
// SETUP/ACCESS sequencing with wait states, per-transfer timeout, miss errors.
module bus_apb_bridge
  import bus_apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           NUM_SLAVES      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned           SLAVE_SPAN_LOG2 = 12,
  parameter int unsigned           TIMEOUT_CYCLES  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             bus_ena,
  input  logic [DATA_WIDTH/8-1:0]          bus_wstb,
  input  logic [ADDR_WIDTH-1:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0]            bus_wdata,
  output logic                             bus_ready,
  output logic [DATA_WIDTH-1:0]            bus_rdata,
  output logic                             bus_slverr,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  output logic [2:0]                       pprot,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  output logic                             timeout_evt
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;

  apb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    slverr_q, slverr_d;
  logic                    tevt_q, tevt_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic                    req_write;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  bus_apb_decoder #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_SLAVES      (NUM_SLAVES),
    .BASE_ADDR       (BASE_ADDR),
    .SLAVE_SPAN_LOG2 (SLAVE_SPAN_LOG2),
    .IDX_W           (IDX_W)
  ) u_decoder (
    .addr (bus_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign req_write = bus_is_write(STRB_MAX_W'(bus_wstb));
  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ready_d   = 1'b0;
    rdata_d   = '0;
    slverr_d  = 1'b0;
    tevt_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_ena) begin
          if (dec_hit) begin
            state_d  = SETUP;
            idx_d    = dec_idx;
            cnt_d    = '0;
            paddr_d  = bus_addr;
            pwrite_d = req_write;
            pwdata_d = req_write ? bus_wdata : '0;
            pstrb_d  = req_write ? bus_wstb : '0;
            psel_d   = NUM_SLAVES'(1) << dec_idx;
          end else begin
            state_d  = RESP;
            ready_d  = 1'b1;
            slverr_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A ready in the same cycle the counter hits the limit takes priority.
        if (sel_ready) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          rdata_d  = pwrite_q ? '0 : sel_rdata;
          slverr_d = sel_err;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          tevt_d   = 1'b1;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // APB side is quiet whenever the bus response is presented.
    if (state_d == RESP) begin
      paddr_d   = '0;
      pwrite_d  = 1'b0;
      pwdata_d  = '0;
      pstrb_d   = '0;
      psel_d    = '0;
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      tevt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      tevt_q    <= tevt_d;
    end
  end

  assign bus_ready   = ready_q;
  assign bus_rdata   = rdata_q;
  assign bus_slverr  = slverr_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = APB_PROT_DEFAULT;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign timeout_evt = tevt_q;

endmodule
